// File: rtl/soc_addr_rules_pkg.sv
// rtl/soc_addr_rules_pkg.sv - address map types and the SoC rule table used by soc_addr_router
package soc_addr_rules_pkg;

    localparam int unsigned RULE_ADDR_W = 32;
    localparam int unsigned SOC_N_SLV   = 4;

    typedef logic [RULE_ADDR_W-1:0] addr_t;
    typedef logic [4:0]             id_t;

    // start_addr is inclusive, end_addr is exclusive
    typedef struct packed {
        addr_t start_addr;
        addr_t end_addr;
    } addr_rule_t;

    localparam addr_rule_t RULE_ROM    = '{start_addr: 32'h0000_0000, end_addr: 32'h0000_0800};
    localparam addr_rule_t RULE_SRAM   = '{start_addr: 32'h0000_0800, end_addr: 32'h0000_2800};
    localparam addr_rule_t RULE_TCM    = '{start_addr: 32'h2000_0000, end_addr: 32'h2000_2000};
    localparam addr_rule_t RULE_PERIPH = '{start_addr: 32'h1000_0000, end_addr: 32'h1FFF_0000};

    localparam addr_rule_t [SOC_N_SLV-1:0] SOC_RULES = {RULE_PERIPH, RULE_TCM, RULE_SRAM, RULE_ROM};

endpackage

// File: rtl/soc_route_fifo.sv
// rtl/soc_route_fifo.sv - destination-id FIFO recording issue order of outstanding requests
module soc_route_fifo
    import soc_addr_rules_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("soc_route_fifo: DEPTH must be a power of two in 2..16");
    end

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/soc_addr_router.sv
// rtl/soc_addr_router.sv - N-target address router with in-order responses; SOC_ADDR_ROUTER_DEFAULT_SLV_EN sends unmapped requests to DEFAULT_SLV
module soc_addr_router
    import soc_addr_rules_pkg::*;
#(
    parameter int unsigned            N_SLV       = 4,
    parameter int unsigned            MAX_OUTST   = 4,
    parameter int unsigned            ADDR_W      = 32,
    parameter int unsigned            DATA_W      = 32,
    parameter addr_rule_t [N_SLV-1:0] RULES       = SOC_RULES,
    parameter int unsigned            DEFAULT_SLV = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_W-1:0]       req_addr_i,
    input  logic                    req_we_i,
    input  logic [DATA_W/8-1:0]     req_be_i,
    input  logic [DATA_W-1:0]       req_wdata_i,
    output logic                    rsp_valid_o,
    output logic [DATA_W-1:0]       rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [N_SLV-1:0]        slv_req_valid_o,
    input  logic [N_SLV-1:0]        slv_req_ready_i,
    output logic [ADDR_W-1:0]       slv_addr_o,
    output logic                    slv_we_o,
    output logic [DATA_W/8-1:0]     slv_be_o,
    output logic [DATA_W-1:0]       slv_wdata_o,
    input  logic [N_SLV-1:0]        slv_rsp_valid_i,
    output logic [N_SLV-1:0]        slv_rsp_ready_o,
    input  logic [N_SLV*DATA_W-1:0] slv_rsp_rdata_i,
    input  logic [N_SLV-1:0]        slv_rsp_err_i
);

`ifdef SOC_ADDR_ROUTER_DEFAULT_SLV_EN
    localparam int unsigned     ID_W       = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam logic [ID_W-1:0] UNMAPPED_ID = ID_W'(DEFAULT_SLV);
`else
    localparam int unsigned     ID_W       = $clog2(N_SLV + 1);
    localparam logic [ID_W-1:0] DECERR_ID  = ID_W'(N_SLV);
    localparam logic [ID_W-1:0] UNMAPPED_ID = DECERR_ID;
`endif

    logic [ID_W-1:0] dest;
    logic [ID_W-1:0] head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            tgt_req_ready;
    logic            push;
    logic            pop;

    if ((N_SLV < 1) || (N_SLV > 16)) begin : g_bad_nslv
        $error("soc_addr_router: N_SLV must be in 1..16");
    end
    if (DEFAULT_SLV >= N_SLV) begin : g_bad_default
        $error("soc_addr_router: DEFAULT_SLV must be below N_SLV");
    end
    for (genvar g = 0; g < N_SLV; g++) begin : g_rule_chk
        if (RULES[g].start_addr >= RULES[g].end_addr) begin : g_bad_rule
            $error("soc_addr_router: rule %0d start must be below end", g);
        end
    end

    // Scanning from the top index down lets the lowest matching rule win
    always_comb begin
        dest = UNMAPPED_ID;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((req_addr_i >= ADDR_W'(RULES[i].start_addr)) &&
                (req_addr_i <  ADDR_W'(RULES[i].end_addr))) begin
                dest = ID_W'(i);
            end
        end
    end

    // A full FIFO blocks even when a pop is under way: no rsp->req combinational path
    always_comb begin
        slv_req_valid_o = '0;
        tgt_req_ready   = 1'b0;
`ifndef SOC_ADDR_ROUTER_DEFAULT_SLV_EN
        if (dest == DECERR_ID) begin
            tgt_req_ready = 1'b1;
        end
`endif
        for (int i = 0; i < N_SLV; i++) begin
            if (dest == ID_W'(i)) begin
                slv_req_valid_o[i] = req_valid_i & ~fifo_full;
                tgt_req_ready      = slv_req_ready_i[i];
            end
        end
    end

    assign req_ready_o = ~fifo_full & tgt_req_ready;
    assign push        = req_valid_i & req_ready_o;

    assign slv_addr_o  = req_addr_i;
    assign slv_we_o    = req_we_i;
    assign slv_be_o    = req_be_i;
    assign slv_wdata_o = req_wdata_i;

    soc_route_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (ID_W)
    ) u_route_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i (dest),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Only the head target sees ready; later targets hold their responses
    always_comb begin
        slv_rsp_ready_o = '0;
        rsp_valid_o     = 1'b0;
        rsp_rdata_o     = '0;
        rsp_err_o       = 1'b0;
        if (!fifo_empty) begin
            for (int i = 0; i < N_SLV; i++) begin
                if (head == ID_W'(i)) begin
                    slv_rsp_ready_o[i] = 1'b1;
                    rsp_valid_o        = slv_rsp_valid_i[i];
                    rsp_rdata_o        = slv_rsp_rdata_i[i*DATA_W +: DATA_W];
                    rsp_err_o          = slv_rsp_err_i[i];
                end
            end
`ifndef SOC_ADDR_ROUTER_DEFAULT_SLV_EN
            if (head == DECERR_ID) begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = 1'b1;
            end
`endif
        end
    end

    assign pop = rsp_valid_o;

endmodule

// File: doc/soc_addr_router.md
Name: soc_addr_router

Overview:
- Parametrised N-target request router between a core data/instruction port and N_SLV memory-mapped targets.
- Decodes each request against a rule table of start/end ranges, forwards it to the matching target, and tracks outstanding requests so responses return to the master in issue order.
- Unmapped addresses get an internally generated decode-error response.
- Sits between the core interface and SRAM/ROM/peripheral-bus ports, replacing fixed per-target range compares.

Parameters:
- N_SLV, 4, number of target ports (1..16).
- MAX_OUTST, 4, maximum in-flight requests; power of two, 2..16.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enable is DATA_W/8.
- RULES, 4 x addr_rule_t, per-target range; start inclusive, end exclusive; entry i maps to target i.
- DEFAULT_SLV, 0, target index used for unmapped addresses when SOC_ADDR_ROUTER_DEFAULT_SLV_EN is defined.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  master request valid
- req_ready_o  out  1  master request accepted
- req_addr_i  in  ADDR_W  request address
- req_we_i  in  1  write enable
- req_be_i  in  DATA_W/8  byte enables
- req_wdata_i  in  DATA_W  write data
- rsp_valid_o  out  1  response to master; master always accepts
- rsp_rdata_o  out  DATA_W  read data
- rsp_err_o  out  1  error (target error or decode error)
- slv_req_valid_o  out  N_SLV  per-target request valid
- slv_req_ready_i  in  N_SLV  per-target request ready
- slv_addr_o / slv_we_o / slv_be_o / slv_wdata_o  out  ADDR_W/1/DATA_W/8/DATA_W  broadcast request fields
- slv_rsp_valid_i  in  N_SLV  per-target response valid
- slv_rsp_ready_o  out  N_SLV  per-target response ready
- slv_rsp_rdata_i  in  N_SLV*DATA_W  per-target read data
- slv_rsp_err_i  in  N_SLV  per-target error

Behaviour:
- Decode (combinational):
  - Hit[i] = (addr >= RULES[i].start) && (addr < RULES[i].end), unsigned, ADDR_W-bit.
  - Overlapping rules: lowest index wins.
  - No hit: destination = DECERR, encoded as id N_SLV.
- Route FIFO: MAX_OUTST entries of destination id, width clog2(N_SLV+1); count width clog2(MAX_OUTST+1).
- Request path:
  - slv_req_valid_o[d] = req_valid_i & (dest==d) & !full.
  - req_ready_o = !full & (dest==DECERR ? 1 : slv_req_ready_i[dest]).
  - Push dest on req_valid_i & req_ready_o.
  - Request fields are pass-through, zero added latency.
- Response path:
  - slv_rsp_ready_o[i] = !empty & (head==i).
  - rsp_valid_o = !empty & (head==DECERR ? 1 : slv_rsp_valid_i[head]).
  - rsp_rdata_o = selected target data, or 0 for DECERR; rsp_err_o = target err, or 1 for DECERR.
  - Pop on rsp_valid_o.
  - A target's rsp_valid while not at head is held off (ready low); it is never dropped.
- Latency: decode-error response earliest the cycle after acceptance; target responses earliest the cycle after acceptance, then as fast as the target.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: req_ready_o=0 even if a pop occurs the same cycle; no bypass, to avoid a rsp->req combinational path.
- Empty: rsp_valid_o=0, all slv_rsp_ready_o=0.
- Pointers wrap modulo MAX_OUTST.
- Reset (async assert, sync deassert by SoC reset logic):
  - FIFO empty, pointers 0.
  - rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
  - slv_req_valid_o=0, slv_rsp_ready_o=0.
- Reset mid-transaction: all in-flight tracking is discarded; targets must be reset together.
- Elaboration checks: RULES[i].start < RULES[i].end; DEFAULT_SLV < N_SLV.

Optional Feature:
- SOC_ADDR_ROUTER_DEFAULT_SLV_EN defined: unmapped addresses route to DEFAULT_SLV, which owns the error response; DECERR is never generated and the FIFO id width is clog2(N_SLV).
- Undefined: internal decode-error responder as described in Behaviour.

Decomposition:
- soc_addr_rules_pkg holds: addr_t, id_t, addr_rule_t, per-target rule constants, and a SOC-level rule-array constant for RULES.
- Router-local constant: DECERR id = N_SLV.
- One sub-module: soc_route_fifo, the parametrised id FIFO with count, full and empty.

Test Plan:
All scenarios use RULES = {0x0000_0000–0x0000_0800, 0x0000_0800–0x0000_2800, 0x2000_0000–0x2000_2000, 0x1000_0000–0x1FFF_0000}.
- Read 0x0000_07FC, then read 0x0000_0800 -> issued to target 0 then target 1; responses returned in issue order even if target 1 answers first.
- Read 0x3000_0000 -> no target valid, req_ready_o=1, next cycle rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0.
- Overlap: RULES[0]=0x0–0x1FFF_0000 with 0x1000_0004 -> target 0 selected.
- Four requests to target 2 that stall responses -> 5th request sees req_ready_o=0; after one response, ready returns the following cycle.
- Reset asserted with 3 outstanding -> rsp_valid_o=0 and FIFO empty immediately; after release, a fresh read to 0x2000_0000 completes normally.
- With SOC_ADDR_ROUTER_DEFAULT_SLV_EN, DEFAULT_SLV=3, read 0x3000_0000 -> slv_req_valid_o[3]=1; the response comes from target 3.
